// File: rtl/multicycle_pkg.sv
// Shared constants for the RV32I-subset multicycle controller: state codes, opcodes,
// ALU operation encodings and datapath mux selects.
package multicycle_pkg;

  typedef logic [3:0] state_t;

  localparam state_t StFetch    = 4'd0;
  localparam state_t StDecode   = 4'd1;
  localparam state_t StMemAdr   = 4'd2;
  localparam state_t StMemRead  = 4'd3;
  localparam state_t StMemWb    = 4'd4;
  localparam state_t StMemWrite = 4'd5;
  localparam state_t StExecR    = 4'd6;
  localparam state_t StExecI    = 4'd7;
  localparam state_t StAluWb    = 4'd8;
  localparam state_t StBeq      = 4'd9;
  localparam state_t StJal      = 4'd10;
  localparam state_t StTrap     = 4'd11;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpItype  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluXor = 3'b100;
  localparam logic [2:0] AluSlt = 3'b101;
  localparam logic [2:0] AluSll = 3'b110;
  localparam logic [2:0] AluSrl = 3'b111;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResData      = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcAReg   = 2'b10;

  localparam logic [1:0] SrcBReg  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic [1:0] ImmI = 2'b00;
  localparam logic [1:0] ImmS = 2'b01;
  localparam logic [1:0] ImmB = 2'b10;
  localparam logic [1:0] ImmJ = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// Maps funct3/funct7b5 to an ALU operation for R-type and I-type arithmetic.
module alu_decoder
  import multicycle_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       rtype_i,
  output logic [2:0] alu_control_o
);

  always_comb begin
    alu_control_o = AluAdd;
    case (funct3_i)
      // Bit 30 of an I-type is immediate data, so sub exists only for R-type.
      3'b000:  alu_control_o = (rtype_i && funct7b5_i) ? AluSub : AluAdd;
      3'b001:  alu_control_o = AluSll;
      3'b010:  alu_control_o = AluSlt;
      3'b100:  alu_control_o = AluXor;
      3'b101:  alu_control_o = AluSrl;
      3'b110:  alu_control_o = AluOr;
      3'b111:  alu_control_o = AluAnd;
      default: alu_control_o = AluAdd;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I-subset control FSM with sticky illegal-instruction trap.
// Define MULTICYCLE_CONTROL_BNE_EN to also accept bne (branch funct3=001).
module multicycle_control
  import multicycle_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       trap
);

  state_t     state_q, state_d;
  logic       trap_q;
  logic       branch_ok;
  logic       branch_taken;
  logic [2:0] dec_alu;

  alu_decoder u_alu_decoder (
    .funct3_i      (funct3),
    .funct7b5_i    (funct7b5),
    .rtype_i       (state_q == StExecR),
    .alu_control_o (dec_alu)
  );

`ifdef MULTICYCLE_CONTROL_BNE_EN
  assign branch_ok    = (funct3 == 3'b000) || (funct3 == 3'b001);
  assign branch_taken = (funct3 == 3'b001) ? ~Zero : Zero;
`else
  assign branch_ok    = (funct3 == 3'b000);
  assign branch_taken = Zero;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:    if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRtype:         state_d = (funct3 == 3'b011) ? StTrap : StExecR;
          OpItype:         state_d = (funct3 == 3'b011) ? StTrap : StExecI;
          OpBranch:        state_d = branch_ok ? StBeq : StTrap;
          OpJal:           state_d = StJal;
          default:         state_d = StTrap;
        endcase
      end
      StMemAdr:   state_d = (op == OpStore) ? StMemWrite : StMemRead;
      StMemRead:  if (mem_ready) state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: if (mem_ready) state_d = StFetch;
      StExecR:    state_d = StAluWb;
      StExecI:    state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBeq:      state_d = StFetch;
      StJal:      state_d = StAluWb;
      StTrap:     state_d = StTrap;
      default:    state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StFetch;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == StTrap) trap_q <= 1'b1;
    end
  end

  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = ResAluOut;
    ALUSrcA    = SrcAPc;
    ALUSrcB    = SrcBReg;
    ALUControl = AluAdd;
    unique case (state_q)
      StFetch: begin
        ALUSrcB   = SrcBFour;
        ResultSrc = ResAluResult;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      StDecode: begin
        ALUSrcA = SrcAOldPc;
        ALUSrcB = SrcBImm;
      end
      StMemAdr: begin
        ALUSrcA = SrcAReg;
        ALUSrcB = SrcBImm;
      end
      StMemRead:  AdrSrc = 1'b1;
      StMemWb: begin
        ResultSrc = ResData;
        RegWrite  = 1'b1;
      end
      StMemWrite: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      StExecR: begin
        ALUSrcA    = SrcAReg;
        ALUSrcB    = SrcBReg;
        ALUControl = dec_alu;
      end
      StExecI: begin
        ALUSrcA    = SrcAReg;
        ALUSrcB    = SrcBImm;
        ALUControl = dec_alu;
      end
      StAluWb:    RegWrite = 1'b1;
      StBeq: begin
        ALUSrcA    = SrcAReg;
        ALUSrcB    = SrcBReg;
        ALUControl = AluSub;
        PCWrite    = branch_taken;
      end
      StJal: begin
        ALUSrcA = SrcAOldPc;
        ALUSrcB = SrcBFour;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
    // Reset overrides any state so no architectural write can escape.
    if (!rst_n) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end

  always_comb begin
    case (op)
      OpStore:  ImmSrc = ImmS;
      OpBranch: ImmSrc = ImmB;
      OpJal:    ImmSrc = ImmJ;
      default:  ImmSrc = ImmI;
    endcase
  end

  assign trap = trap_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: a per-instruction step model pushes expected
// control vectors; a negedge monitor compares them against the DUT.
module tb_multicycle_control;

  localparam logic [6:0] TLw = 7'b0000011, TSw = 7'b0100011, TR = 7'b0110011;
  localparam logic [6:0] TI = 7'b0010011, TBr = 7'b1100011, TJal = 7'b1101111;

  // Instruction steps as seen from outside the controller.
  localparam int PF = 0, PD = 1, PA = 2, PR = 3, PW = 4, PS = 5;
  localparam int PER = 6, PEI = 7, PAW = 8, PB = 9, PJ = 10, PT = 11;

  logic clk = 1'b0;
  logic rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic funct7b5, Zero, mem_ready;
  logic PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, trap;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  multicycle_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .IRWrite    (IRWrite),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .AdrSrc     (AdrSrc),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .trap       (trap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] exp;
    int          ph;
  } sb_t;

  sb_t sb[$];
  int n_checks = 0;
  int n_pass = 0;
  logic model_trap = 1'b0;
  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic cur_f7;
  string pname [12] = '{"fetch", "decode", "memadr", "memread", "memwb", "memwrite",
                        "executer", "executei", "aluwb", "branch", "jal", "trap"};

  function automatic logic rb();
    return 1'($urandom & 1);
  endfunction

  function automatic logic [2:0] alu_ref(input logic [2:0] f3, input logic f7, input logic isr);
    case (f3)
      3'd0:    return (isr && f7) ? 3'd1 : 3'd0;
      3'd1:    return 3'd6;
      3'd2:    return 3'd5;
      3'd4:    return 3'd4;
      3'd5:    return 3'd7;
      3'd6:    return 3'd3;
      3'd7:    return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [1:0] imm_ref(input logic [6:0] o);
    if (o == TSw) return 2'b01;
    if (o == TBr) return 2'b10;
    if (o == TJal) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic legal(input logic [6:0] o, input logic [2:0] f3);
    if (o == TLw || o == TSw || o == TJal) return 1'b1;
    if (o == TR || o == TI) return f3 != 3'd3;
`ifdef MULTICYCLE_CONTROL_BNE_EN
    if (o == TBr) return f3 == 3'd0 || f3 == 3'd1;
`else
    if (o == TBr) return f3 == 3'd0;
`endif
    return 1'b0;
  endfunction

  // Packed as {PCWrite,IRWrite,MemWrite,RegWrite,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,
  // ImmSrc,trap}.
  function automatic logic [16:0] expect_out(input int ph, input logic mr, input logic z,
                                             input logic rst, input logic trp);
    logic pcw = 1'b0, irw = 1'b0, mw = 1'b0, rw = 1'b0, adr = 1'b0;
    logic [1:0] res = 2'b00, sa = 2'b00, sbsel = 2'b00;
    logic [2:0] alu = 3'd0;
    case (ph)
      PF:  begin sbsel = 2'b10; res = 2'b10; irw = mr; pcw = mr; end
      PD:  begin sa = 2'b01; sbsel = 2'b01; end
      PA:  begin sa = 2'b10; sbsel = 2'b01; end
      PR:  adr = 1'b1;
      PW:  begin res = 2'b01; rw = 1'b1; end
      PS:  begin adr = 1'b1; mw = 1'b1; end
      PER: begin sa = 2'b10; alu = alu_ref(cur_f3, cur_f7, 1'b1); end
      PEI: begin sa = 2'b10; sbsel = 2'b01; alu = alu_ref(cur_f3, cur_f7, 1'b0); end
      PAW: rw = 1'b1;
      PB:  begin sa = 2'b10; alu = 3'd1; pcw = (cur_f3 == 3'd1) ? ~z : z; end
      PJ:  begin sa = 2'b01; sbsel = 2'b10; pcw = 1'b1; end
      default: ;
    endcase
    if (!rst) {pcw, irw, mw, rw} = 4'b0000;
    return {pcw, irw, mw, rw, adr, res, sa, sbsel, alu, imm_ref(cur_op), trp};
  endfunction

  always @(negedge clk) begin
    sb_t e;
    logic [16:0] got;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      got = {PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB,
             ALUControl, ImmSrc, trap};
      n_checks++;
      if (got === e.exp) n_pass++;
      else $display("FAIL %s @%0t: got %b required %b (op=%b f3=%b)", pname[e.ph], $time,
                    got, e.exp, cur_op, cur_f3);
    end
  end

  task automatic cycle(input int ph, input logic mr, input logic z);
    mem_ready = mr;
    Zero = z;
    sb.push_back('{exp: expect_out(ph, mr, z, rst_n, model_trap), ph: ph});
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cycle(input int ph, input logic mr);
    rst_n = 1'b0;
    mem_ready = mr;
    Zero = rb();
    sb.push_back('{exp: expect_out(ph, mr, Zero, rst_n, model_trap), ph: ph});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_trap = 1'b0;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    cur_op = o; cur_f3 = f3; cur_f7 = f7;
    op = o; funct3 = f3; funct7b5 = f7;
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int fs, input int ms, input logic zb, input int ntrap);
    set_instr(o, f3, f7);
    repeat (fs) cycle(PF, 1'b0, rb());
    cycle(PF, 1'b1, rb());
    cycle(PD, rb(), rb());
    if (!legal(o, f3)) begin
      model_trap = 1'b1;
      repeat (ntrap) cycle(PT, rb(), rb());
      reset_cycle(PT, rb());
      return;
    end
    if (o == TLw) begin
      cycle(PA, rb(), rb());
      repeat (ms) cycle(PR, 1'b0, rb());
      cycle(PR, 1'b1, rb());
      cycle(PW, rb(), rb());
    end else if (o == TSw) begin
      cycle(PA, rb(), rb());
      repeat (ms) cycle(PS, 1'b0, rb());
      cycle(PS, 1'b1, rb());
    end else if (o == TR) begin
      cycle(PER, rb(), rb());
      cycle(PAW, rb(), rb());
    end else if (o == TI) begin
      cycle(PEI, rb(), rb());
      cycle(PAW, rb(), rb());
    end else if (o == TBr) begin
      cycle(PB, rb(), zb);
    end else begin
      cycle(PJ, rb(), rb());
      cycle(PAW, rb(), rb());
    end
  endtask

  function automatic logic [2:0] rand_alu_f3();
    int k = int'($urandom_range(0, 6));
    return 3'(k >= 3 ? k + 1 : k);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6:0] bad_ops [4];
    bad_ops[0] = 7'b1111111; bad_ops[1] = 7'b0110111;
    bad_ops[2] = 7'b1100111; bad_ops[3] = 7'b0000000;
    rst_n = 1'b0;
    set_instr(7'd0, 3'd0, 1'b0);
    mem_ready = 1'b1;
    Zero = 1'b0;
    @(posedge clk);
    #1;
    reset_cycle(PF, 1'b1);

    n_checks++;
    if (trap === 1'b0) n_pass++;
    else $display("FAIL post-reset trap=%b", trap);
    n_checks++;
    if (ALUSrcB === 2'b10) n_pass++;
    else $display("FAIL post-reset ALUSrcB=%b", ALUSrcB);
    n_checks++;
    if (ResultSrc === 2'b10) n_pass++;
    else $display("FAIL post-reset ResultSrc=%b", ResultSrc);
    n_checks++;
    if (AdrSrc === 1'b0) n_pass++;
    else $display("FAIL post-reset AdrSrc=%b", AdrSrc);

    run_instr(TLw, 3'd2, 1'b0, 0, 0, 1'b0, 1);
    run_instr(TR, 3'd0, 1'b1, 0, 0, 1'b0, 1);
    run_instr(TI, 3'd0, 1'b1, 1, 0, 1'b0, 1);
    run_instr(TBr, 3'd0, 1'b0, 0, 0, 1'b1, 1);
    run_instr(TBr, 3'd0, 1'b0, 0, 0, 1'b0, 1);
    run_instr(TBr, 3'd1, 1'b0, 0, 0, 1'b1, 3);
    run_instr(TBr, 3'd1, 1'b0, 0, 0, 1'b0, 3);
    run_instr(TSw, 3'd2, 1'b0, 0, 3, 1'b0, 1);
    run_instr(TJal, 3'd0, 1'b0, 2, 0, 1'b0, 1);
    run_instr(7'b1111111, 3'd0, 1'b0, 0, 0, 1'b0, 10);
    run_instr(TR, 3'd3, 1'b0, 0, 0, 1'b0, 2);
    run_instr(TLw, 3'd2, 1'b0, 1, 2, 1'b0, 1);

    // Reset in the middle of a store must drop MemWrite and restart at fetch.
    set_instr(TSw, 3'd2, 1'b0);
    cycle(PF, 1'b1, 1'b0);
    cycle(PD, 1'b1, 1'b0);
    cycle(PA, 1'b1, 1'b0);
    cycle(PS, 1'b0, 1'b0);
    reset_cycle(PS, 1'b0);

    for (int i = 0; i < 80; i++) begin
      int kind = int'($urandom_range(0, 9));
      int fs = int'($urandom_range(0, 2));
      int ms = int'($urandom_range(0, 2));
      int nt = int'($urandom_range(1, 4));
      case (kind)
        0: run_instr(TLw, 3'd2, rb(), fs, ms, rb(), nt);
        1: run_instr(TSw, 3'd2, rb(), fs, ms, rb(), nt);
        2: run_instr(TR, rand_alu_f3(), rb(), fs, ms, rb(), nt);
        3: run_instr(TI, rand_alu_f3(), rb(), fs, ms, rb(), nt);
        4: run_instr(TBr, 3'd0, rb(), fs, ms, rb(), nt);
        5: run_instr(TBr, 3'd1, rb(), fs, ms, rb(), nt);
        6: run_instr(TJal, 3'(rb()), rb(), fs, ms, rb(), nt);
        7: run_instr(bad_ops[$urandom_range(0, 3)], 3'($urandom), rb(), fs, ms, rb(), nt);
        8: run_instr(rb() ? TR : TI, 3'd3, rb(), fs, ms, rb(), nt);
        default: run_instr(TBr, 3'($urandom_range(2, 7)), rb(), fs, ms, rb(), nt);
      endcase
    end

    @(negedge clk);
    #1;
    if (n_pass != n_checks) $display("FAIL %0d of %0d checks failed", n_checks - n_pass,
                                     n_checks);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
